lsu_mem_ctrl: RTL and testbench

- Parametrised load/store controller between the MEM stage and a variable-latency data SRAM port. It replaces the purely combinational byte-lane shell.
- Accepts one load or store per handshake and generates byte strobes and lane-replicated write data.
- Tracks one outstanding memory transaction through a request/address-ack/data-ack handshake, stalling the pipeline meanwhile.
- Returns sign- or zero-extended load data.
- Detects misaligned accesses (AdEL/AdES) and supports flush of an in-flight access.

---
 rtl/lsu_pkg.sv | 62 ++++++
 rtl/lsu_mem_ctrl_if.sv | 46 ++++
 rtl/lsu_lane_align.sv | 24 ++
 rtl/lsu_mem_ctrl.sv | 102 ++++++++++
 tb/tb_lsu_mem_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store memory controller.
// Helpers work on a 64-bit / 8-lane view; callers narrow the results to DATA_W.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DRAIN,
    ST_RESP
  } state_t;

  function automatic logic [7:0] strb_gen(input logic [1:0] size, input logic [2:0] ofs);
    logic [15:0] m;
    m = ((16'd1 << (5'd1 << size)) - 16'd1) << ofs;
    return m[7:0];
  endfunction

  function automatic logic [63:0] wdata_rep(input logic [1:0] size, input logic [63:0] wdata);
    logic [63:0] r;
    case (size)
      SIZE_B:  r = {8{wdata[7:0]}};
      SIZE_H:  r = {4{wdata[15:0]}};
      SIZE_W:  r = {2{wdata[31:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] rdata_ext(input logic [1:0] size, input logic sign,
                                            input logic [2:0] ofs, input logic [63:0] rdata);
    logic [63:0] sh;
    logic [63:0] r;
    sh = rdata >> {ofs, 3'b000};
    case (size)
      SIZE_B:  r = {{56{sign & sh[7]}},  sh[7:0]};
      SIZE_H:  r = {{48{sign & sh[15]}}, sh[15:0]};
      SIZE_W:  r = {{32{sign & sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  // wide = 1 when the data path is 64 bits, so full-width accesses are legal
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] ofs,
                                      input logic wide);
    logic m;
    case (size)
      SIZE_B:  m = 1'b0;
      SIZE_H:  m = ofs[0];
      SIZE_W:  m = |ofs[1:0];
      default: m = !wide || (|ofs);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// MEM-stage request/response and data-SRAM port bundle for lsu_mem_ctrl.
// slave = controller view, master = pipeline plus memory view.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              flush;
  logic              ready;
  logic              stall;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              exc_adel;
  logic              exc_ades;
  logic [ADDR_W-1:0] badvaddr;
  logic              mem_req;
  logic              mem_wr;
  logic [NB-1:0]     mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, flush,
           mem_addr_ok, mem_data_ok, mem_rdata,
    output ready, stall, resp_valid, resp_rdata, exc_adel, exc_ades, badvaddr,
           mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, flush,
           mem_addr_ok, mem_data_ok, mem_rdata,
    input  ready, stall, resp_valid, resp_rdata, exc_adel, exc_ades, badvaddr,
           mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobes and replicated write data, load
// byte extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OFS = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [OFS-1:0]    ofs,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     strb,
  output logic [DATA_W-1:0] wrep,
  output logic [DATA_W-1:0] rext
);

  assign strb = NB'(strb_gen(size, 3'(ofs)));
  assign wrep = DATA_W'(wdata_rep(size, 64'(wdata)));
  assign rext = DATA_W'(rdata_ext(size, sign, 3'(ofs), 64'(rdata)));

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one outstanding access to a variable-latency data
// SRAM with misalignment detection, pipeline stall and flush handling.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            rst,
  lsu_mem_ctrl_if.slave  bus
);

  localparam int NB  = DATA_W / 8;
  localparam int OFS = $clog2(NB);

  state_t state, state_nxt;

  logic              accept;
  logic              mis;
  logic              we_p0;
  logic              sign_p0;
  logic              exc_p0;
  logic [1:0]        size_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic [NB-1:0]     strb;
  logic [DATA_W-1:0] wrep;
  logic [DATA_W-1:0] rext;
  logic              in_req;
  logic              resp;

  assign accept = (state == ST_IDLE) && bus.req_valid && !bus.flush;
  assign mis    = misaligned(bus.req_size, 3'(bus.req_addr[OFS-1:0]), DATA_W == 64);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // p0: request latched on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      size_p0  <= bus.req_size;
      sign_p0  <= bus.req_sign;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
      exc_p0   <= mis;
    end
  end

  // p1: read data captured on data_ok
  always_ff @(posedge clk) begin
    if (state == ST_WAIT && bus.mem_data_ok) rdata_p1 <= bus.mem_rdata;
  end

  // flush wins over every same-cycle handshake; a flush coinciding with
  // data_ok in WAIT has nothing left to drain
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = mis ? ST_RESP : ST_REQ;
      ST_REQ:   if (bus.flush)            state_nxt = ST_IDLE;
                else if (bus.mem_addr_ok) state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.flush)            state_nxt = bus.mem_data_ok ? ST_IDLE : ST_DRAIN;
                else if (bus.mem_data_ok) state_nxt = ST_RESP;
      ST_DRAIN: if (bus.mem_data_ok)      state_nxt = ST_IDLE;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .size  (size_p0),
    .sign  (sign_p0),
    .ofs   (addr_p0[OFS-1:0]),
    .wdata (wdata_p0),
    .rdata (rdata_p1),
    .strb  (strb),
    .wrep  (wrep),
    .rext  (rext)
  );

  assign in_req = (state == ST_REQ);
  assign resp   = (state == ST_RESP) && !bus.flush;

  assign bus.ready      = (state == ST_IDLE);
  assign bus.stall      = bus.req_valid && ((state != ST_IDLE) || accept) && !bus.flush;
  assign bus.mem_req    = in_req;
  assign bus.mem_wr     = in_req && we_p0;
  assign bus.mem_wstrb  = (in_req && we_p0) ? strb : '0;
  assign bus.mem_addr   = in_req ? {addr_p0[ADDR_W-1:OFS], {OFS{1'b0}}} : '0;
  assign bus.mem_wdata  = (in_req && we_p0) ? wrep : '0;
  assign bus.resp_valid = resp;
  assign bus.exc_adel   = resp && exc_p0 && !we_p0;
  assign bus.exc_ades   = resp && exc_p0 && we_p0;
  assign bus.badvaddr   = (resp && exc_p0) ? addr_p0 : '0;
  assign bus.resp_rdata = (resp && !exc_p0 && !we_p0) ? rext : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomised bench for lsu_mem_ctrl: the bench plays pipeline and memory and
// compares every cycle against a byte-level reference model.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] last_rdata;

  lsu_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  lsu_mem_ctrl_if #(.ADDR_W(32), .DATA_W(64)) bus64 ();

  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // fl: 0 none, 1 flush in REQ, 2 flush in WAIT, 3 flush in RESP
  task automatic access(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int adly, input int ddly, input int fl);
    int n, o;
    logic mis, gone;
    logic [3:0]  e_strb;
    logic [31:0] e_wd, e_rd;
    n = 1 << size;
    o = int'(addr % 4);
    mis = (o % n != 0) || (size == 2'd3);
    for (int i = 0; i < 4; i++) begin
      e_strb[i]      = we && (i >= o) && (i < o + n);
      e_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    e_rd = '0;
    if (!mis && !we) begin
      for (int k = 0; k < n; k++) e_rd[8*k +: 8] = rd[8*(o+k) +: 8];
      if (sign && e_rd[8*n-1]) for (int k = n; k < 4; k++) e_rd[8*k +: 8] = 8'hFF;
    end
    gone = 1'b0;

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size; bus.req_sign = sign;
    bus.req_addr = addr; bus.req_wdata = wd; bus.flush = 1'b0;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0;
    #1;
    chk("ready_idle", bus.ready, 1);
    chk("stall_acc", bus.stall, 1);
    chk("memreq_idle", bus.mem_req, 0);

    if (mis) begin
      @(negedge clk);
      bus.flush = (fl == 3);
      #1;
      chk("exc_rv", bus.resp_valid, fl != 3);
      chk("exc_adel", bus.exc_adel, (fl != 3) && !we);
      chk("exc_ades", bus.exc_ades, (fl != 3) && we);
      if (fl != 3) begin
        chk("exc_badvaddr", bus.badvaddr, addr);
        chk("exc_rdata", bus.resp_rdata, 0);
      end
      chk("exc_memreq", bus.mem_req, 0);
    end else begin
      for (int c = 0; c <= adly && !gone; c++) begin
        @(negedge clk);
        bus.flush       = (fl == 1) && (c == adly);
        bus.mem_addr_ok = (c == adly) && (fl != 1);
        #1;
        chk("req_mem_req", bus.mem_req, 1);
        chk("req_mem_wr", bus.mem_wr, we);
        chk("req_mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
        chk("req_wstrb", bus.mem_wstrb, e_strb);
        if (we) chk("req_wdata", bus.mem_wdata, e_wd);
        chk("req_ready", bus.ready, 0);
        chk("req_stall", bus.stall, !bus.flush);
        chk("req_rv", bus.resp_valid, 0);
        if ((fl == 1) && (c == adly)) gone = 1'b1;
      end
      if (!gone) begin
        for (int w = 0; w < ddly; w++) begin
          @(negedge clk);
          bus.mem_addr_ok = 1'b0;
          if (w > 0 && fl == 2) bus.req_valid = 1'b0;
          bus.flush       = (fl == 2) && (w == 0);
          bus.mem_data_ok = (w == ddly - 1);
          bus.mem_rdata   = (w == ddly - 1) ? rd : $urandom;
          #1;
          chk("wait_memreq", bus.mem_req, 0);
          chk("wait_ready", bus.ready, 0);
          chk("wait_rv", bus.resp_valid, 0);
          chk("wait_stall", bus.stall, fl != 2);
        end
        if (fl != 2) begin
          @(negedge clk);
          bus.mem_data_ok = 1'b0;
          bus.flush = (fl == 3);
          #1;
          chk("resp_rv", bus.resp_valid, fl != 3);
          if (fl != 3) chk("resp_rdata", bus.resp_rdata, e_rd);
          last_rdata = bus.resp_rdata;
          chk("resp_adel", bus.exc_adel, 0);
          chk("resp_ades", bus.exc_ades, 0);
          chk("resp_memreq", bus.mem_req, 0);
        end
      end
    end

    @(negedge clk);
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0;
    #1;
    chk("end_ready", bus.ready, 1);
    chk("end_rv", bus.resp_valid, 0);
    chk("end_memreq", bus.mem_req, 0);
  endtask

  task automatic acc64(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       input logic [7:0] e_strb, input logic [63:0] e_wd,
                       input logic [63:0] e_rd, input logic exc);
    @(negedge clk);
    bus64.req_valid = 1'b1; bus64.req_we = we; bus64.req_size = size; bus64.req_sign = sign;
    bus64.req_addr = addr; bus64.req_wdata = wd;
    if (!exc) begin
      @(negedge clk);
      bus64.mem_addr_ok = 1'b1;
      #1;
      chk("d64_memreq", bus64.mem_req, 1);
      chk("d64_wstrb", bus64.mem_wstrb, e_strb);
      chk("d64_addr", bus64.mem_addr, addr & 32'hFFFF_FFF8);
      if (we) chk("d64_wdata", bus64.mem_wdata, e_wd);
      @(negedge clk);
      bus64.mem_addr_ok = 1'b0; bus64.mem_data_ok = 1'b1; bus64.mem_rdata = rd;
    end
    @(negedge clk);
    bus64.mem_data_ok = 1'b0;
    #1;
    chk("d64_rv", bus64.resp_valid, 1);
    chk("d64_rdata", bus64.resp_rdata, e_rd);
    chk("d64_adel", bus64.exc_adel, exc && !we);
    chk("d64_ades", bus64.exc_ades, exc && we);
    if (exc) chk("d64_badvaddr", bus64.badvaddr, addr);
    @(negedge clk);
    bus64.req_valid = 1'b0;
    #1;
    chk("d64_ready", bus64.ready, 1);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] ad;
    int fl, n;

    rst = 1'b1;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_sign = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.flush = 0;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = 0;
    bus64.req_valid = 0; bus64.req_we = 0; bus64.req_size = 0; bus64.req_sign = 0;
    bus64.req_addr = 0; bus64.req_wdata = 0; bus64.flush = 0;
    bus64.mem_addr_ok = 0; bus64.mem_data_ok = 0; bus64.mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_stall", bus.stall, 0);
    chk("rst_memreq", bus.mem_req, 0);
    chk("rst_rv", bus.resp_valid, 0);
    chk("rst_wstrb", bus.mem_wstrb, 0);
    rst = 1'b0;

    // SB 0x1003: strobe lane 3, data replicated, best-case latency
    access(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, 32'h0, 0, 1, 0);
    // LH / LHU at 0x2002
    access(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 0, 1, 0);
    chk("lh_const", last_rdata, 32'hFFFF_8001);
    access(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 0, 1, 0);
    chk("lhu_const", last_rdata, 32'h0000_8001);
    // misaligned load and store
    access(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 0, 1, 0);
    access(1'b1, 2'd1, 1'b0, 32'h3003, 32'h1234, 32'h0, 0, 1, 0);
    // slow memory
    access(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'hDEAD_BEEF, 3, 4, 0);
    chk("lw_slow_const", last_rdata, 32'hDEAD_BEEF);
    // flush in WAIT, then LBU 0x11
    access(1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 32'h1111_2222, 0, 3, 2);
    access(1'b0, 2'd0, 1'b0, 32'h0000_0011, 32'h0, 32'h0000_F000, 0, 1, 0);
    chk("lbu_const", last_rdata, 32'h0000_00F0);
    // flush in REQ and in RESP
    access(1'b1, 2'd2, 1'b0, 32'h6004, 32'hCAFE_F00D, 32'h0, 2, 1, 1);
    access(1'b0, 2'd0, 1'b1, 32'h6005, 32'h0, 32'h0000_8000, 0, 2, 3);
    access(1'b0, 2'd2, 1'b0, 32'h6001, 32'h0, 32'h0, 0, 1, 3);

    // reset while waiting for data
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h40;
    @(negedge clk);
    bus.mem_addr_ok = 1'b1;
    @(negedge clk);
    bus.mem_addr_ok = 1'b0;
    #1;
    chk("rstw_ready_pre", bus.ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.req_valid = 1'b0;
    #1;
    chk("rstw_ready", bus.ready, 1);
    chk("rstw_stall", bus.stall, 0);
    chk("rstw_memreq", bus.mem_req, 0);
    chk("rstw_rv", bus.resp_valid, 0);
    chk("rstw_rdata", bus.resp_rdata, 0);
    chk("rstw_adel", bus.exc_adel, 0);

    for (int it = 0; it < 150; it++) begin
      sz = 2'($urandom_range(0, 3));
      n  = 1 << sz;
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad = ad & ~(32'(n) - 32'd1);
      fl = $urandom_range(0, 7);
      if (fl > 3) fl = 0;
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, $urandom,
             $urandom_range(0, 3), (fl == 2) ? $urandom_range(2, 4) : $urandom_range(1, 4), fl);
    end

    // 64-bit data path
    acc64(1'b1, 2'd3, 1'b0, 32'h8, 64'h0123_4567_89AB_CDEF, 64'h0,
          8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0);
    acc64(1'b0, 2'd3, 1'b0, 32'h10, 64'h0, 64'hFEDC_BA98_7654_3210,
          8'h00, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b0);
    acc64(1'b0, 2'd2, 1'b1, 32'h14, 64'h0, 64'h8000_0000_0000_0000,
          8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0);
    acc64(1'b1, 2'd0, 1'b0, 32'h0D, 64'h5A, 64'h0,
          8'h20, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0, 1'b0);
    acc64(1'b0, 2'd3, 1'b0, 32'h4, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
